// File: rtl/jstk_spi_responder_if.sv
//----------------------------------------------------------------------------
// jstk_spi_responder_if
//   SPI pin bundle between a mode-0 master and the joystick responder.
//   SS      : slave select, active-low (master -> slave)
//   SCLK    : SPI clock, idle low      (master -> slave)
//   MOSI    : master-to-slave data, MSB first
//   MISO    : slave-to-master data, MSB first
//   miso_oe : MISO output enable, high only while a frame is active
//----------------------------------------------------------------------------
`timescale 1ns/1ps
interface jstk_spi_responder_if;
  logic SS;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic miso_oe;

  modport master (output SS, output SCLK, output MOSI, input MISO, input miso_oe);
  modport slave  (input SS, input SCLK, input MOSI, output MISO, output miso_oe);
endinterface

// File: rtl/jstk_spi_responder.sv
//----------------------------------------------------------------------------
// jstk_spi_responder
//   SPI mode-0 slave emulating the PmodJSTK joystick. All SPI pins are
//   oversampled on clk (SCLK must be <= clk/8); no logic runs on SCLK.
//   Each frame returns 5 bytes, MSB first, byte0 first:
//     joy_x[7:0], {6'b0,joy_x[9:8]}, joy_y[7:0], {6'b0,joy_y[9:8]}, {5'b0,btn}
//   and captures the first received byte as the LED command.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   spi        SPI pins (slave modport: SS, SCLK, MOSI in; MISO, miso_oe out)
//   joy_x/joy_y/btn  values to report, snapshotted at the start of each frame
//   led        command[1:0] of the last accepted frame
//   frame_done one-clk pulse after a complete 40-bit frame was accepted
//   frame_err  one-clk pulse after an aborted, overlong or rejected frame
//   busy       high while a frame is being shifted
//
// Build option:
//   JSTK_CMD_CHECK_EN  when defined, a complete frame is accepted only if
//                      command[7:2] == 6'b100000; otherwise it is an error.
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module jstk_spi_responder #(
  parameter int NUM_BYTES   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  jstk_spi_responder_if.slave       spi,
  input  logic [9:0]                joy_x,
  input  logic [9:0]                joy_y,
  input  logic [2:0]                btn,
  output logic [1:0]                led,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int FRAME_BITS = NUM_BYTES * 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  // Input synchronizers, loaded with the idle line levels on reset.
  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   ss_prev_q, sclk_prev_q;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_rise, sclk_rise, sclk_fall;

  state_t                 state_q, state_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  // Only 7 received bits are stored: the 8th comes straight from MOSI at
  // the moment the command byte is latched.
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             cmd_q, cmd_d;
  // MISO is the MSB of the transmit register; clearing it idles MISO low.
  logic [FRAME_BITS-1:0]  tx_q, tx_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [1:0]             led_q, led_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic                   cmd_ok;

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

`ifdef JSTK_CMD_CHECK_EN
  assign cmd_ok = (cmd_q[7:2] == 6'b100000);
`else
  assign cmd_ok = 1'b1;
  // Upper command bits only matter when command checking is built in.
  logic unused_cmd_hi;
  assign unused_cmd_hi = ^cmd_q[7:2];
`endif

  // State register and all datapath/output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync_q    <= '1;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ss_prev_q    <= 1'b1;
      sclk_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      cmd_q        <= '0;
      tx_q         <= '0;
      miso_oe_q    <= 1'b0;
      led_q        <= 2'b00;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], spi.SS};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
      ss_prev_q    <= ss_s;
      sclk_prev_q  <= sclk_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      cmd_q        <= cmd_d;
      tx_q         <= tx_d;
      miso_oe_q    <= miso_oe_d;
      led_q        <= led_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic. IDLE starts on a low synchronized SS level rather than
  // a fall pulse, so a fall that landed during DONE is still honoured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!ss_s)  state_d = ST_SHIFT;
      ST_SHIFT: if (ss_rise) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and outputs. Frame completion is resolved on the SS-rise
  // transition so the pulse and led update coincide with the DONE clk.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    cmd_d        = cmd_q;
    tx_d         = tx_q;
    miso_oe_d    = miso_oe_q;
    led_d        = led_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (!ss_s) begin
          tx_d      = FRAME_BITS'({joy_x[7:0], 6'b0, joy_x[9:8],
                                   joy_y[7:0], 6'b0, joy_y[9:8],
                                   5'b0, btn});
          bit_cnt_d = '0;
          rx_d      = '0;
          cmd_d     = '0;
          miso_oe_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          // A coincident SCLK edge is deliberately ignored here.
          tx_d      = '0;
          miso_oe_d = 1'b0;
          busy_d    = 1'b0;
          if ((bit_cnt_q == 6'(FRAME_BITS)) && cmd_ok) begin
            frame_done_d = 1'b1;
            led_d        = cmd_q[1:0];
          end else begin
            frame_err_d  = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_d = {rx_q[5:0], mosi_s};
          if (bit_cnt_q == 6'd7)
            cmd_d = {rx_q, mosi_s};
          if (bit_cnt_q != 6'(FRAME_BITS + 1))
            bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (sclk_fall) begin
          // Zeros shift in, so bits beyond the frame read back as 0.
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  assign spi.MISO    = tx_q[FRAME_BITS-1];
  assign spi.miso_oe = miso_oe_q;
  assign led         = led_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: doc/jstk_spi_responder.md
Name: jstk_spi_responder

Overview:
- SPI mode-0 slave that emulates the PmodJSTK joystick end of the link.
- Returns a 5-byte joystick report (10-bit X, 10-bit Y, 3 buttons) to the existing SPI master and captures the master's LED command byte.
- Used as the bench-side joystick model for the Battleship top, and as a board-to-board joystick source.
- SPI pins are oversampled on the system clock; there is no SCLK-domain logic.

Parameters:
- NUM_BYTES, 5, bytes per frame. Fixed by protocol; values other than 5 are unsupported.
- SYNC_STAGES, 2, flip-flop depth of the SS/SCLK/MOSI input synchronizers (minimum 2).

Ports:
- clk  in  1  system clock (100 MHz); SCLK must be no faster than clk/8.
- reset  in  1  asynchronous, active-high.
- SS  in  1  slave select from master, active-low.
- SCLK  in  1  SPI clock from master, idle low.
- MOSI  in  1  master-to-slave data, MSB first.
- MISO  out  1  slave-to-master data, MSB first.
- miso_oe  out  1  MISO output enable; high only while a frame is active.
- joy_x  in  10  X position to report.
- joy_y  in  10  Y position to report.
- btn  in  3  button states to report.
- led  out  2  LED bits from the last accepted command byte.
- frame_done  out  1  one-clk pulse after a complete 40-bit frame.
- frame_err  out  1  one-clk pulse after an aborted or overlong frame.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset: all of the following apply immediately and asynchronously:
  - MISO=0, miso_oe=0, led=2'b00, frame_done=0, frame_err=0, busy=0.
  - Synchronizers are loaded with their idle values (SS=1, SCLK=0, MOSI=0).
  - FSM goes to IDLE; bit and byte counters clear.
  - Reset mid-frame drops the frame with no pulse.
- Edge detection uses the synchronized signals: SS fall, SS rise, SCLK rise, SCLK fall.
- Frame layout, MSB first; byte0 is sent first:
  - byte0 = joy_x[7:0]
  - byte1 = {6'b0, joy_x[9:8]}
  - byte2 = joy_y[7:0]
  - byte3 = {6'b0, joy_y[9:8]}
  - byte4 = {5'b0, btn[2:0]}
- FSM states and transitions:
  - IDLE: on SS fall, snapshot joy_x/joy_y/btn into a 40-bit shift register, drive MISO with bit 39, set miso_oe=1 and busy=1, go to SHIFT.
    - First MISO bit must be valid within SYNC_STAGES+2 clk of SS falling at the pin.
  - SHIFT, on SCLK rise: shift MOSI into the 8-bit receive register and increment the 6-bit bit counter (saturates at 41).
  - SHIFT, on SCLK fall: advance the transmit register and drive the next bit on MISO. Bits past 40 drive 0.
  - SHIFT: after bit 8 is received, latch the receive register as the command byte.
  - SHIFT, on SS rise: go to DONE.
  - DONE: one clk.
    - If bit count == 40: pulse frame_done and update led from the command.
    - Otherwise: pulse frame_err and leave led unchanged.
    - Then MISO=0, miso_oe=0, busy=0, go to IDLE.
- Gaps between bytes with SS held low are legal; the counters hold across gaps.
- Inputs are snapshotted once per frame; changes mid-frame appear in the next frame only.
- SS rise and SCLK edge in the same clk: the SCLK edge is ignored and SS rise wins.
- An SS fall seen while in DONE is honoured on the following clk; the FSM returns via IDLE, so no SS fall is lost.
- led updates one clk after SS rise is detected.

Optional Feature:
- Macro: JSTK_CMD_CHECK_EN.
- Defined: a complete frame is accepted only if command[7:2] == 6'b100000.
  - Accepted frame: frame_done pulse, led = command[1:0].
  - Rejected frame: frame_err pulse, led unchanged.
- Undefined: every complete frame takes led = command[1:0] and pulses frame_done, with no command check.

Test Plan:
- Basic frame: x=10'h2A5, y=10'h13C, btn=3'b101, master sends 0x83 at SCLK=1 MHz, 10 µs byte gaps -> master reads A5 02 3C 01 05; led=2'b11; one frame_done pulse; frame_err stays 0.
- Mid-frame change: change x to 10'h001 after byte1 -> current frame still returns A5 02; next frame returns 01 00.
- Abort: SS raised after 17 bits -> one frame_err pulse, no frame_done, led unchanged; the following full frame with 0x82 -> led=2'b10.
- Overlong: 48 SCLK cycles -> bits 41..48 on MISO read 0; frame_err pulse; led unchanged.
- Reset: reset asserted after 20 bits, released, then a full frame with 0x81 -> no pulse during reset; outputs at reset values; then led=2'b01 and one frame_done.
- Command check, with JSTK_CMD_CHECK_EN defined: command 0x43 -> frame_err, led unchanged. Without the macro: led=2'b11 and frame_done.
